// File: rtl/rs_age_select_if.sv
// Dispatch, CDB broadcast and issue bundle of the age-select reservation station.
// The driver side (dispatch/CDB/FU) uses master; the station itself uses slave.
interface rs_age_select_if #(
  parameter int RS_SIZE     = 16,
  parameter int DP_WIDTH    = 2,
  parameter int CDB_WIDTH   = 2,
  parameter int ISSUE_WIDTH = 2,
  parameter int TAG_W       = 5,
  parameter int XLEN        = 32,
  parameter int PAYLOAD_W   = 64
);
  logic                             squash;
  logic [DP_WIDTH-1:0]              dp_valid;
  logic [DP_WIDTH*TAG_W-1:0]        dp_tag1;
  logic [DP_WIDTH*TAG_W-1:0]        dp_tag2;
  logic [DP_WIDTH-1:0]              dp_rdy1;
  logic [DP_WIDTH-1:0]              dp_rdy2;
  logic [DP_WIDTH*XLEN-1:0]         dp_val1;
  logic [DP_WIDTH*XLEN-1:0]         dp_val2;
  logic [DP_WIDTH*PAYLOAD_W-1:0]    dp_payload;
  logic [CDB_WIDTH-1:0]             cdb_valid;
  logic [CDB_WIDTH*TAG_W-1:0]       cdb_tag;
  logic [CDB_WIDTH*XLEN-1:0]        cdb_value;
  logic [ISSUE_WIDTH-1:0]           fu_free;
  logic [$clog2(RS_SIZE+1)-1:0]     free_count;
  logic                             full;
  logic [ISSUE_WIDTH-1:0]           is_valid;
  logic [ISSUE_WIDTH*XLEN-1:0]      is_val1;
  logic [ISSUE_WIDTH*XLEN-1:0]      is_val2;
  logic [ISSUE_WIDTH*PAYLOAD_W-1:0] is_payload;

  modport master (
    output squash, dp_valid, dp_tag1, dp_tag2, dp_rdy1, dp_rdy2, dp_val1, dp_val2,
           dp_payload, cdb_valid, cdb_tag, cdb_value, fu_free,
    input  free_count, full, is_valid, is_val1, is_val2, is_payload
  );

  modport slave (
    input  squash, dp_valid, dp_tag1, dp_tag2, dp_rdy1, dp_rdy2, dp_val1, dp_val2,
           dp_payload, cdb_valid, cdb_tag, cdb_value, fu_free,
    output free_count, full, is_valid, is_val1, is_val2, is_payload
  );
endinterface

// File: rtl/rs_age_select.sv
// Parametrised reservation station: multi-lane dispatch, CDB wakeup, registered issue lanes.
// Define RS_AGE_SELECT_EN for oldest-first select via an age matrix; otherwise lowest-index-first.
module rs_age_select #(
  parameter int RS_SIZE     = 16,
  parameter int DP_WIDTH    = 2,
  parameter int CDB_WIDTH   = 2,
  parameter int ISSUE_WIDTH = 2,
  parameter int TAG_W       = 5,
  parameter int XLEN        = 32,
  parameter int PAYLOAD_W   = 64
) (
  input logic            clock,
  input logic            reset,
  rs_age_select_if.slave bus
);
  localparam int IDX_W = $clog2(RS_SIZE);
  localparam int CNT_W = $clog2(RS_SIZE + 1);

  logic [RS_SIZE-1:0]   ent_valid;
  logic [RS_SIZE-1:0]   ent_rdy1;
  logic [RS_SIZE-1:0]   ent_rdy2;
  logic [TAG_W-1:0]     ent_tag1    [RS_SIZE];
  logic [TAG_W-1:0]     ent_tag2    [RS_SIZE];
  logic [XLEN-1:0]      ent_val1    [RS_SIZE];
  logic [XLEN-1:0]      ent_val2    [RS_SIZE];
  logic [PAYLOAD_W-1:0] ent_payload [RS_SIZE];

  logic [CNT_W-1:0]     free_cnt;
  logic                 dp_contig;
  int                   alloc_n;
  logic [DP_WIDTH-1:0]  dp_ok;
  logic [IDX_W-1:0]     dp_idx [DP_WIDTH];
  logic [DP_WIDTH-1:0]  dp_r1;
  logic [DP_WIDTH-1:0]  dp_r2;
  logic [XLEN-1:0]      dp_v1 [DP_WIDTH];
  logic [XLEN-1:0]      dp_v2 [DP_WIDTH];

  logic [RS_SIZE-1:0]   wk1;
  logic [RS_SIZE-1:0]   wk2;
  logic [XLEN-1:0]      wk_val1 [RS_SIZE];
  logic [XLEN-1:0]      wk_val2 [RS_SIZE];

  logic [RS_SIZE-1:0]     eligible;
  logic [RS_SIZE-1:0]     taken;
  logic [RS_SIZE-1:0]     cand;
  logic [RS_SIZE-1:0]     oldest;
  logic [ISSUE_WIDTH-1:0] sel_ok;
  logic [IDX_W-1:0]       sel_idx [ISSUE_WIDTH];

  logic [ISSUE_WIDTH-1:0]           is_valid_q;
  logic [ISSUE_WIDTH*XLEN-1:0]      is_val1_q;
  logic [ISSUE_WIDTH*XLEN-1:0]      is_val2_q;
  logic [ISSUE_WIDTH*PAYLOAD_W-1:0] is_payload_q;
  logic [RS_SIZE-1:0]               valid_nxt;

  always_comb begin
    free_cnt = '0;
    for (int e = 0; e < RS_SIZE; e++) free_cnt = free_cnt + CNT_W'(~ent_valid[e]);
  end

  // Lane k is accepted only as part of a contiguous run from lane 0 that fits in the free entries.
  always_comb begin
    dp_contig = 1'b1;
    dp_ok     = '0;
    alloc_n   = 0;
    for (int k = 0; k < DP_WIDTH; k++) begin
      dp_idx[k] = '0;
      dp_contig = dp_contig & bus.dp_valid[k];
      dp_ok[k]  = dp_contig & ~bus.squash & (CNT_W'(k) < free_cnt);
    end
    for (int e = 0; e < RS_SIZE; e++) begin
      if (!ent_valid[e]) begin
        for (int k = 0; k < DP_WIDTH; k++) begin
          if (alloc_n == k) dp_idx[k] = IDX_W'(e);
        end
        alloc_n = alloc_n + 1;
      end
    end
  end

  // Bus scan runs high to low so the lowest-index matching bus has the last word.
  always_comb begin
    for (int k = 0; k < DP_WIDTH; k++) begin
      dp_r1[k] = bus.dp_rdy1[k];
      dp_r2[k] = bus.dp_rdy2[k];
      dp_v1[k] = bus.dp_val1[k*XLEN +: XLEN];
      dp_v2[k] = bus.dp_val2[k*XLEN +: XLEN];
      for (int c = CDB_WIDTH - 1; c >= 0; c--) begin
        if (bus.cdb_valid[c] && !bus.dp_rdy1[k] &&
            bus.dp_tag1[k*TAG_W +: TAG_W] == bus.cdb_tag[c*TAG_W +: TAG_W]) begin
          dp_r1[k] = 1'b1;
          dp_v1[k] = bus.cdb_value[c*XLEN +: XLEN];
        end
        if (bus.cdb_valid[c] && !bus.dp_rdy2[k] &&
            bus.dp_tag2[k*TAG_W +: TAG_W] == bus.cdb_tag[c*TAG_W +: TAG_W]) begin
          dp_r2[k] = 1'b1;
          dp_v2[k] = bus.cdb_value[c*XLEN +: XLEN];
        end
      end
    end
  end

  always_comb begin
    for (int e = 0; e < RS_SIZE; e++) begin
      wk1[e]     = 1'b0;
      wk2[e]     = 1'b0;
      wk_val1[e] = ent_val1[e];
      wk_val2[e] = ent_val2[e];
      for (int c = CDB_WIDTH - 1; c >= 0; c--) begin
        if (bus.cdb_valid[c] && ent_tag1[e] == bus.cdb_tag[c*TAG_W +: TAG_W]) begin
          wk1[e]     = 1'b1;
          wk_val1[e] = bus.cdb_value[c*XLEN +: XLEN];
        end
        if (bus.cdb_valid[c] && ent_tag2[e] == bus.cdb_tag[c*TAG_W +: TAG_W]) begin
          wk2[e]     = 1'b1;
          wk_val2[e] = bus.cdb_value[c*XLEN +: XLEN];
        end
      end
    end
  end

`ifdef RS_AGE_SELECT_EN
  logic [RS_SIZE-1:0][RS_SIZE-1:0] age;
  logic [RS_SIZE-1:0][RS_SIZE-1:0] age_nxt;

  // New entries lose to every valid entry and to lower dispatch lanes of the same cycle.
  always_comb begin
    age_nxt = age;
    for (int k = 0; k < DP_WIDTH; k++) begin
      if (dp_ok[k]) begin
        for (int x = 0; x < RS_SIZE; x++) begin
          age_nxt[dp_idx[k]][x] = 1'b0;
          age_nxt[x][dp_idx[k]] = ent_valid[x];
        end
        for (int j = 0; j < k; j++) begin
          if (dp_ok[j]) age_nxt[dp_idx[j]][dp_idx[k]] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) age <= '0;
    else        age <= age_nxt;
  end
`endif

  assign eligible = ent_valid & ent_rdy1 & ent_rdy2;

  always_comb begin
    taken  = '0;
    sel_ok = '0;
    cand   = '0;
    oldest = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      sel_idx[i] = '0;
      if (bus.fu_free[i]) begin
        cand = eligible & ~taken;
`ifdef RS_AGE_SELECT_EN
        for (int a = 0; a < RS_SIZE; a++) begin
          oldest[a] = cand[a];
          for (int b = 0; b < RS_SIZE; b++) begin
            if (b != a && cand[b] && !age[a][b]) oldest[a] = 1'b0;
          end
        end
`else
        oldest = cand;
`endif
        for (int a = RS_SIZE - 1; a >= 0; a--) begin
          if (oldest[a]) begin
            sel_ok[i]  = 1'b1;
            sel_idx[i] = IDX_W'(a);
          end
        end
        if (sel_ok[i]) taken[sel_idx[i]] = 1'b1;
      end
    end
  end

  always_comb begin
    valid_nxt = ent_valid & ~taken;
    for (int k = 0; k < DP_WIDTH; k++) begin
      if (dp_ok[k]) valid_nxt[dp_idx[k]] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ent_valid    <= '0;
      is_valid_q   <= '0;
      is_val1_q    <= '0;
      is_val2_q    <= '0;
      is_payload_q <= '0;
    end else if (bus.squash) begin
      ent_valid  <= '0;
      is_valid_q <= '0;
    end else begin
      ent_valid  <= valid_nxt;
      is_valid_q <= sel_ok;
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
        if (sel_ok[i]) begin
          is_val1_q[i*XLEN +: XLEN]            <= ent_val1[sel_idx[i]];
          is_val2_q[i*XLEN +: XLEN]            <= ent_val2[sel_idx[i]];
          is_payload_q[i*PAYLOAD_W +: PAYLOAD_W] <= ent_payload[sel_idx[i]];
        end
      end
    end
  end

  // Entry contents need no reset: nothing reads them while the entry is invalid.
  always_ff @(posedge clock) begin
    for (int e = 0; e < RS_SIZE; e++) begin
      if (!ent_rdy1[e] && wk1[e]) begin
        ent_rdy1[e] <= 1'b1;
        ent_val1[e] <= wk_val1[e];
      end
      if (!ent_rdy2[e] && wk2[e]) begin
        ent_rdy2[e] <= 1'b1;
        ent_val2[e] <= wk_val2[e];
      end
    end
    for (int k = 0; k < DP_WIDTH; k++) begin
      if (dp_ok[k]) begin
        ent_tag1[dp_idx[k]]    <= bus.dp_tag1[k*TAG_W +: TAG_W];
        ent_tag2[dp_idx[k]]    <= bus.dp_tag2[k*TAG_W +: TAG_W];
        ent_rdy1[dp_idx[k]]    <= dp_r1[k];
        ent_rdy2[dp_idx[k]]    <= dp_r2[k];
        ent_val1[dp_idx[k]]    <= dp_v1[k];
        ent_val2[dp_idx[k]]    <= dp_v2[k];
        ent_payload[dp_idx[k]] <= bus.dp_payload[k*PAYLOAD_W +: PAYLOAD_W];
      end
    end
  end

  assign bus.free_count = free_cnt;
  assign bus.full       = (free_cnt == '0);
  assign bus.is_valid   = is_valid_q;
  assign bus.is_val1    = is_val1_q;
  assign bus.is_val2    = is_val2_q;
  assign bus.is_payload = is_payload_q;
endmodule
